// File: rtl/branch_pred_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// The BTB entry is sized for the default address width.
package branch_pred_pkg;

    localparam int unsigned BP_XLEN = 32;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    // Tag is kept full width and zero-extended so the entry layout does not
    // depend on BTB_ENTRIES.
    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
        logic [1:0]         ctr;
    } btb_entry_t;

    function automatic logic [BP_XLEN-1:0] next_seq_pc(input logic [BP_XLEN-1:0] pc);
        return pc + BP_XLEN'(4);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import branch_pred_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_ST) begin
                o_ctr = i_ctr + 2'd1;
            end
        end else begin
            if (i_ctr != CTR_SNT) begin
                o_ctr = i_ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup at fetch,
// training and registered mispredict/redirect from resolved branches.
module branch_predictor
    import branch_pred_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 32,
    parameter int unsigned XLEN        = BP_XLEN
) (
    input  logic            clock,
    input  logic            reset_n,

    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,

    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,

    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned IDX_W     = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_SHIFT = IDX_W + 2;

    btb_entry_t [BTB_ENTRIES-1:0] r_btb;
    logic                         r_mispredict;
    logic [XLEN-1:0]              r_redirect_pc;

    logic [IDX_W-1:0] w_fetch_idx;
    logic [XLEN-1:0]  w_fetch_tag;
    logic [XLEN-1:0]  w_fetch_seq;
    btb_entry_t       w_fetch_entry;
    logic             w_fetch_hit;

    logic [IDX_W-1:0] w_upd_idx;
    logic [XLEN-1:0]  w_upd_tag;
    btb_entry_t       w_upd_cur;
    btb_entry_t       w_upd_next;
    logic             w_upd_hit;
    logic             w_upd_we;
    logic [1:0]       w_upd_ctr_next;
    logic [XLEN-1:0]  w_actual_next;
    logic             w_mispredict;

    // Lookup
    assign w_fetch_idx   = fetch_pc[IDX_W+1:2];
    assign w_fetch_tag   = fetch_pc >> TAG_SHIFT;
    assign w_fetch_seq   = next_seq_pc(fetch_pc);
    assign w_fetch_entry = r_btb[w_fetch_idx];

    // Gated by reset_n so a lookup in a reset cycle misses even though the
    // table only clears at the edge.
    assign w_fetch_hit = fetch_valid & reset_n & w_fetch_entry.valid &
                         (w_fetch_entry.tag == w_fetch_tag);

    always_comb begin
        pred_hit    = 1'b0;
        pred_taken  = 1'b0;
        pred_target = '0;
        if (fetch_valid) begin
            pred_hit    = w_fetch_hit;
            pred_taken  = w_fetch_hit & w_fetch_entry.ctr[1];
            pred_target = pred_taken ? w_fetch_entry.target : w_fetch_seq;
        end
    end

    // Training
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc >> TAG_SHIFT;
    assign w_upd_cur = r_btb[w_upd_idx];
    assign w_upd_hit = w_upd_cur.valid & (w_upd_cur.tag == w_upd_tag);

    sat_counter2 u_sat_counter2 (
        .i_ctr   (w_upd_cur.ctr),
        .i_taken (upd_taken),
        .o_ctr   (w_upd_ctr_next)
    );

    always_comb begin
        w_upd_next = w_upd_cur;
        w_upd_we   = 1'b0;
        if (upd_valid) begin
            if (w_upd_hit) begin
                w_upd_we       = 1'b1;
                w_upd_next.ctr = w_upd_ctr_next;
                if (upd_taken) begin
                    w_upd_next.target = upd_target;
                end
            end else if (upd_taken) begin
                w_upd_we          = 1'b1;
                w_upd_next.valid  = 1'b1;
                w_upd_next.tag    = w_upd_tag;
                w_upd_next.target = upd_target;
                w_upd_next.ctr    = CTR_ALLOC;
            end
        end
    end

    // Mispredict detection against the prediction carried with the branch
    assign w_actual_next = upd_taken ? upd_target : next_seq_pc(upd_pc);
    assign w_mispredict  = upd_valid & ((upd_taken != upd_pred_taken) |
                                        (upd_pred_target != w_actual_next));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            if (w_upd_we) begin
                r_btb[w_upd_idx] <= w_upd_next;
            end
            r_mispredict <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= w_actual_next;
            end
        end
    end

    assign mispredict  = r_mispredict;
    assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor (32-entry BTB): lookup
// checked before each edge, mispredict/redirect checked just after it.
module tb_branch_predictor;

    logic        clock;
    logic        reset_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predictor #(
        .BTB_ENTRIES (32),
        .XLEN        (32)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        e_hit;
        logic        e_taken;
        logic [31:0] e_target;
        logic        e_mis;
        logic [31:0] e_redir;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fv, input logic [31:0] fpc,
                                input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utgt, input logic upt,
                                input logic [31:0] uptgt, input logic e_hit,
                                input logic e_taken, input logic [31:0] e_target,
                                input logic e_mis, input logic [31:0] e_redir);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.upt = upt; v.uptgt = uptgt; v.e_hit = e_hit; v.e_taken = e_taken;
        v.e_target = e_target; v.e_mis = e_mis; v.e_redir = e_redir;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fetch_valid = 1'b0; fetch_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
    endtask

    initial begin
        //        fv fpc           uv upc           ut utgt          upt uptgt
        //        hit tk target        mis redirect
        vecs.push_back(mk(1, 32'h0000_1000, 0, 32'h0,         0, 32'h0,         0, 32'h0,
                          0, 0, 32'h0000_1004, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0000_1000, 1, 32'h0000_1000, 1, 32'h0000_2000, 0, 32'h0000_1004,
                          0, 0, 32'h0000_1004, 1, 32'h0000_2000));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 32'h0000_1000, 1, 32'h0000_1000, 1, 32'h0000_2000, 1,
                              32'h0000_2000, 1, 1, 32'h0000_2000, 0, 32'h0000_2000));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1, 32'h0000_1000, 1, 32'h0000_1000, 0, 32'h0, 1, 32'h0000_2000,
                              1, 1, 32'h0000_2000, 1, 32'h0000_1004));
        vecs.push_back(mk(1, 32'h0000_1000, 0, 32'h0,         0, 32'h0,         0, 32'h0,
                          1, 0, 32'h0000_1004, 0, 32'h0000_1004));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1, 32'h0000_1000, 1, 32'h0000_1000, 0, 32'h0, 0, 32'h0000_1004,
                              1, 0, 32'h0000_1004, 0, 32'h0000_1004));
        // From a held 00 one taken update lands on 01: still predicts not-taken
        vecs.push_back(mk(1, 32'h0000_1000, 1, 32'h0000_1000, 1, 32'h0000_2000, 0, 32'h0000_1004,
                          1, 0, 32'h0000_1004, 1, 32'h0000_2000));
        vecs.push_back(mk(1, 32'h0000_1000, 0, 32'h0,         0, 32'h0,         0, 32'h0,
                          1, 0, 32'h0000_1004, 0, 32'h0000_2000));
        // Aliasing on index 0
        vecs.push_back(mk(1, 32'h0000_1080, 1, 32'h0000_1080, 1, 32'h0000_3000, 0, 32'h0000_1084,
                          0, 0, 32'h0000_1084, 1, 32'h0000_3000));
        vecs.push_back(mk(1, 32'h0000_1000, 0, 32'h0,         0, 32'h0,         0, 32'h0,
                          0, 0, 32'h0000_1004, 0, 32'h0000_3000));
        vecs.push_back(mk(1, 32'h0000_1080, 0, 32'h0,         0, 32'h0,         0, 32'h0,
                          1, 1, 32'h0000_3000, 0, 32'h0000_3000));
        vecs.push_back(mk(1, 32'h0000_5000, 1, 32'h0000_5000, 0, 32'h0, 0, 32'h0000_5004,
                          0, 0, 32'h0000_5004, 0, 32'h0000_3000));
        vecs.push_back(mk(1, 32'h0000_5000, 0, 32'h0,         0, 32'h0,         0, 32'h0,
                          0, 0, 32'h0000_5004, 0, 32'h0000_3000));
        vecs.push_back(mk(1, 32'h0000_1080, 0, 32'h0,         0, 32'h0,         0, 32'h0,
                          1, 1, 32'h0000_3000, 0, 32'h0000_3000));
        // Same-cycle lookup/update: lookup sees pre-update state
        vecs.push_back(mk(1, 32'h0000_1000, 1, 32'h0000_1000, 1, 32'h0000_2000, 0, 32'h0000_1004,
                          0, 0, 32'h0000_1004, 1, 32'h0000_2000));
        vecs.push_back(mk(1, 32'h0000_1000, 1, 32'h0000_1000, 1, 32'h0000_2000, 1, 32'h0000_2000,
                          1, 1, 32'h0000_2000, 0, 32'h0000_2000));
        vecs.push_back(mk(1, 32'h0000_1000, 1, 32'h0000_1000, 1, 32'h0000_2400, 1, 32'h0000_2000,
                          1, 1, 32'h0000_2000, 1, 32'h0000_2400));
        vecs.push_back(mk(1, 32'h0000_1000, 0, 32'h0,         0, 32'h0,         0, 32'h0,
                          1, 1, 32'h0000_2400, 0, 32'h0000_2400));
        // +4 wrap, fetch_valid=0, low PC bits ignored
        vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0,         0, 32'h0,
                          0, 0, 32'h0000_0000, 0, 32'h0000_2400));
        vecs.push_back(mk(0, 32'h0000_1000, 0, 32'h0,         0, 32'h0,         0, 32'h0,
                          0, 0, 32'h0000_0000, 0, 32'h0000_2400));
        vecs.push_back(mk(1, 32'h0000_1002, 0, 32'h0,         0, 32'h0,         0, 32'h0,
                          1, 1, 32'h0000_2400, 0, 32'h0000_2400));

        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check("reset mispredict", {31'b0, mispredict}, 32'h0);
        check("reset redirect_pc", redirect_pc, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clock);
            fetch_valid = vecs[i].fv; fetch_pc = vecs[i].fpc;
            upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
            upd_target = vecs[i].utgt; upd_pred_taken = vecs[i].upt;
            upd_pred_target = vecs[i].uptgt;
            #1;
            check($sformatf("v%0d pred_hit", i), {31'b0, pred_hit}, {31'b0, vecs[i].e_hit});
            check($sformatf("v%0d pred_taken", i), {31'b0, pred_taken},
                  {31'b0, vecs[i].e_taken});
            check($sformatf("v%0d pred_target", i), pred_target, vecs[i].e_target);
            @(posedge clock);
            #1;
            check($sformatf("v%0d mispredict", i), {31'b0, mispredict}, {31'b0, vecs[i].e_mis});
            check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_redir);
        end

        // Reset colliding with a mispredicting allocation: the update is dropped
        @(negedge clock);
        reset_n = 1'b0;
        fetch_valid = 1'b1; fetch_pc = 32'h0000_1000;
        upd_valid = 1'b1; upd_pc = 32'h0000_1000; upd_taken = 1'b1;
        upd_target = 32'h0000_3000; upd_pred_taken = 1'b0; upd_pred_target = 32'h0000_1004;
        #1;
        check("rst lookup pred_hit", {31'b0, pred_hit}, 32'h0);
        check("rst lookup pred_target", pred_target, 32'h0000_1004);
        @(posedge clock);
        #1;
        check("rst+upd mispredict", {31'b0, mispredict}, 32'h0);
        check("rst+upd redirect_pc", redirect_pc, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        idle_inputs();
        fetch_valid = 1'b1; fetch_pc = 32'h0000_1000;
        #1;
        check("post-rst 0x1000 pred_hit", {31'b0, pred_hit}, 32'h0);
        check("post-rst 0x1000 pred_target", pred_target, 32'h0000_1004);
        @(posedge clock);
        #1;
        check("post-rst mispredict", {31'b0, mispredict}, 32'h0);
        @(negedge clock);
        fetch_pc = 32'h0000_1080;
        #1;
        check("post-rst 0x1080 pred_hit", {31'b0, pred_hit}, 32'h0);
        check("post-rst 0x1080 pred_taken", {31'b0, pred_taken}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side counterpart to the execute-stage branch unit. It predicts direction and target for each fetched PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. The BTB is trained by the resolved outcome (`cond`, `target_pc`) that the branch unit produces at execute. The block also registers a mispredict/redirect pulse that fetch uses to recover.

## Interface
Parameters:
- `BTB_ENTRIES`, default 32: number of entries; power of two, ≥2. `IDX_W = $clog2(BTB_ENTRIES)`.
- `XLEN`, default from `sys_defs.svh` (32): address width.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `fetch_valid` in 1: lookup request this cycle.
- `fetch_pc` in XLEN: PC to predict.
- `pred_hit` out 1: valid entry with a matching tag.
- `pred_taken` out 1: predicted direction.
- `pred_target` out XLEN: predicted next PC.
- `upd_valid` in 1: resolved conditional branch from execute.
- `upd_pc` in XLEN: PC of the resolved branch.
- `upd_taken` in 1: actual direction (branch unit `cond`).
- `upd_target` in XLEN: actual taken target (branch unit `target_pc`).
- `upd_pred_taken` in 1: prediction carried down the pipe with the branch.
- `upd_pred_target` in XLEN: predicted next PC carried with the branch.
- `mispredict` out 1: registered one-cycle recovery pulse.
- `redirect_pc` out XLEN: correct next PC, valid while `mispredict`=1.

## Operation
- Address split:
  - index = `pc[IDX_W+1:2]`.
  - tag = `pc[XLEN-1:IDX_W+2]`.
  - `pc[1:0]` is ignored.
- Entry fields: `valid`, `tag`, `target[XLEN-1:0]`, `ctr[1:0]`.
- Lookup is combinational from the current table state:
  - hit = `fetch_valid & valid[idx] & (tag[idx]==fetch_tag)`.
  - On a hit: `pred_taken = ctr[1]`; `pred_target = pred_taken ? target : fetch_pc+4`.
  - On a miss: `pred_hit=0`, `pred_taken=0`, `pred_target = fetch_pc+4`.
  - When `fetch_valid=0`: all three lookup outputs are 0.
  - `+4` wraps modulo 2^XLEN.
- Update (applied at the clock edge when `upd_valid=1`):
  - Hit, taken: `ctr` increments, saturating at 11; `target` is overwritten with `upd_target`.
  - Hit, not taken: `ctr` decrements, saturating at 00; `target` is unchanged.
  - Miss, taken: allocate the entry, overwriting any previous occupant: `valid=1`, new tag, `target=upd_target`, `ctr=10`.
  - Miss, not taken: no table change.
- Mispredict detection:
  - actual_next = `upd_taken ? upd_target : upd_pc+4`.
  - A mispredict occurs when `upd_valid & ((upd_taken != upd_pred_taken) | (upd_pred_target != actual_next))`.
  - On a mispredict, the next edge registers `mispredict=1` and `redirect_pc = actual_next`.
  - Otherwise the next edge registers `mispredict=0`; `redirect_pc` holds its last value.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

## Timing
- Lookup has zero latency: combinational from `fetch_pc` to the `pred_*` outputs.
- The table update becomes visible to lookup one cycle after `upd_valid`.
- When an update and a lookup hit the same index in the same cycle, the lookup sees the pre-update state. There is no bypass.
- `mispredict` and `redirect_pc` are registered. They assert exactly one cycle after `upd_valid` and last one cycle per update.
- Back-to-back updates are accepted every cycle. Each update produces its own `mispredict` result in the following cycle.
- Reset (`reset_n=0` at an edge):
  - All `valid` bits clear; every `ctr` goes to 01; `tag` and `target` go to 0.
  - `mispredict=0` and `redirect_pc=0`.
  - Reset has priority over a simultaneous `upd_valid`; that update is dropped.
  - A lookup during reset returns a miss.
- No handshake. The block never stalls: fetch and update are always accepted.

## Structure
- Shared package `branch_pred_pkg`:
  - `btb_entry_t` struct (valid, tag, target, ctr).
  - Counter constants `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`.
  - `CTR_RESET = CTR_WNT`.
  - `CTR_ALLOC = CTR_WT`.
- One sub-module, `sat_counter2`: a combinational 2-bit saturating next-state function (inputs: ctr, taken; output: next ctr).
- Table is a flop array, `btb_entry_t [BTB_ENTRIES-1:0]`; no SRAM macro.

## Test plan
1. Reset, then lookup `0x0000_1000` → `pred_hit=0`, `pred_taken=0`, `pred_target=0x0000_1004`.
2. Update `pc=0x1000`, `taken=1`, `target=0x0000_2000`, `pred_taken=0`, `pred_target=0x1004` → next cycle `mispredict=1`, `redirect_pc=0x2000`. Lookup `0x1000` then gives `pred_hit=1`, `pred_taken=1`, `pred_target=0x2000`.
3. Saturation on the entry from scenario 2:
   - Three more taken updates keep `pred_taken=1` (ctr=11).
   - Two not-taken updates leave ctr at 01, so `pred_taken=0` and `pred_target=0x1004`.
   - Two further not-taken updates hold ctr at 00.
4. Aliasing with `BTB_ENTRIES=32`:
   - Allocate `0x1000` taken, then `0x1080` taken to `0x3000` (same index, different tag).
   - Lookup `0x1000` → miss; lookup `0x1080` → `pred_target=0x3000`.
   - Not-taken update on a missing PC `0x5000` → no allocation; lookup still misses.
5. Same-cycle lookup and update of `0x1000`: lookup returns the old state; the next cycle returns the new state. Correct prediction (`upd_pred_taken=1`, `upd_pred_target=0x2000`, taken to `0x2000`) → `mispredict=0`.
6. Assert `reset_n=0` in the same cycle as `upd_valid=1` → table stays empty, `mispredict=0` next cycle, and lookups miss after reset.
